vmul_arb: RTL and testbench
===========================

# vmul_arb

Two-requester round-robin arbiter and sequencer sharing one `vmul` FP32 multiplier. Each requester presents an operand pair on a valid/ready channel. The block grants one requester and drives the multiplier's `din1`/`din2`/`din_rdy` start handshake. It then waits for `dout_rdy`, with a timeout watchdog, and returns the product to the granted requester on a valid/ready response channel. At most one operation is outstanding.

## Interface
- `TIMEOUT`, default 200: maximum number of WAIT_RES cycles before an error is declared. Legal range 64..255; the counter is 8 bits wide.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 2: bit i means requester i has an operand pair.
- `req_a` in 64: operand A, FP32; bits [32i+31:32i] belong to requester i.
- `req_b` in 64: operand B, FP32, same packing as `req_a`.
- `req_ready` out 2: one-hot grant; request i is accepted in the cycle where `req_valid[i]` and `req_ready[i]` are both 1.
- `rsp_valid` out 2: one-hot; a result is pending for requester i.
- `rsp_ready` in 2: requester i accepts its result.
- `rsp_data` out 32: FP32 product, valid while any `rsp_valid` bit is high.
- `rsp_err` out 1: timeout flag, qualified by `rsp_valid`.
- `busy` out 1: high in every state except IDLE.
- `mul_din1` out 32: multiplier operand A.
- `mul_din2` out 32: multiplier operand B.
- `mul_din_rdy` out 1: multiplier start strobe.
- `mul_dout` in 32: multiplier result.
- `mul_dout_rdy` in 1: multiplier result-ready level.

## Operation
- States: IDLE, ISSUE, WAIT_RES, RESP.
- Registers:
  - `op_a`, `op_b` (32 bits each): captured operands.
  - `gnt_id` (1 bit): requester currently being served.
  - `last_id` (1 bit): requester served last.
  - `cnt` (8 bits): timeout counter.
  - `res` (32 bits): captured result.
  - `err` (1 bit): captured timeout flag.
- IDLE:
  - `req_ready` is decoded combinationally from `req_valid` and `last_id`.
  - If only one requester is valid, it wins.
  - If both are valid, `~last_id` wins.
  - On a grant: capture `op_a`/`op_b` from the winner's slice, set `gnt_id`, clear `cnt`, go to ISSUE.
  - With no request, remain in IDLE.
- ISSUE, exactly one cycle:
  - `mul_din_rdy`=1, `mul_din1`=`op_a`, `mul_din2`=`op_b`.
  - Go to WAIT_RES.
  - Outside ISSUE, `mul_din_rdy`=0 and `mul_din1`/`mul_din2` hold `op_a`/`op_b`.
- WAIT_RES:
  - The multiplier clears `dout_rdy` on the same edge at which it samples `din_rdy`. Sampling `mul_dout_rdy` from the first WAIT_RES cycle onward is therefore safe.
  - If `mul_dout_rdy`=1: `res`←`mul_dout`, `err`←0, go to RESP.
  - Else if `cnt`==`TIMEOUT`-1: `res`←32'h7FC00000, `err`←1, go to RESP.
  - Otherwise `cnt`←`cnt`+1.
- RESP:
  - `rsp_valid[gnt_id]`=1; `rsp_data`=`res`; `rsp_err`=`err`.
  - Hold until `rsp_ready[gnt_id]`=1. On that edge: `last_id`←`gnt_id`, go to IDLE.
  - `rsp_ready` from the non-granted requester is ignored.
- After a timeout the multiplier may still be mid-operation. The next ISSUE is sent anyway; system-level recovery is to assert reset.
- The multiplier's reset must be released no later than this block's `rst`. The multiplier needs one cycle after reset to reach its wait state, and the earliest possible ISSUE is the second cycle after reset.

## Timing
- Reset values:
  - State IDLE; `last_id`=1, so requester 0 wins the first tie.
  - `op_a`, `op_b`, `res`=0; `err`=0; `cnt`=0; `gnt_id`=0.
  - All outputs 0.
- Reset asserted mid-operation: the FSM returns to IDLE immediately. The pending response is discarded and `rsp_valid` drops asynchronously.
- Latency, with cycle 0 = acceptance cycle:
  - ISSUE occurs in cycle 1.
  - `rsp_valid` rises in cycle k+1, where k is the first WAIT_RES cycle with `mul_dout_rdy`=1.
  - For NaN, Inf and zero operand cases, k=4 and `rsp_valid` rises in cycle 5.
  - A timeout makes `rsp_valid` rise exactly `TIMEOUT`+2 cycles after acceptance.
- Throughput: one operation per (latency + response wait + 1 IDLE cycle). There is no overlap between operations.
- `req_ready` is never high outside IDLE and has at most one bit set.
- `rsp_valid` has at most one bit set and stays stable until its handshake completes.
- `req_valid` may drop without acceptance; there is no penalty and no state change.

## Test plan
- Single request: requester 0 sends a=32'h40000000, b=32'h40400000 → `rsp_valid`=2'b01, `rsp_data`=32'h40C00000, `rsp_err`=0. `mul_din_rdy` is high for exactly one cycle, in cycle 1.
- Special case latency: requester 1 sends a=32'h7F800000, b=32'h00000000 → `rsp_valid`=2'b10 rises in cycle 5; `rsp_data`=32'hFFFFFFFF.
- Contention: both requesters valid continuously with a=32'h3F800000 and b=32'h3F800000, `rsp_ready` tied high → grants alternate 0,1,0,1 over 4 operations; every result is 32'h3F800000.
- Backpressure: hold `rsp_ready[0]`=0 for 20 cycles → `rsp_valid[0]` and `rsp_data` stay stable; `req_ready`=0 throughout; requester 1 is granted only after the handshake completes.
- Timeout: the multiplier model holds `mul_dout_rdy`=0 with `TIMEOUT`=64 → `rsp_valid` rises in cycle 66; `rsp_err`=1; `rsp_data`=32'h7FC00000.
- Reset mid-operation: pulse `rst` low during WAIT_RES → all outputs 0 and `busy`=0 immediately. After release, with both requesters valid, requester 0 wins first.

Source files
------------

// File: rtl/vmul_arb.sv
// Two-requester round-robin front end for a shared vmul FP32 multiplier.
// One operation in flight: grant, issue, wait for the result with a watchdog, then respond.
module vmul_arb #(
  parameter int unsigned TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic [1:0]  req_ready,
  output logic [1:0]  rsp_valid,
  input  logic [1:0]  rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy,
  output logic [31:0] mul_din1,
  output logic [31:0] mul_din2,
  output logic        mul_din_rdy,
  input  logic [31:0] mul_dout,
  input  logic        mul_dout_rdy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RES, RESP} state_t;

  localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  state_t      state_q, state_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic        gnt_id_q, gnt_id_d;
  logic        last_id_q, last_id_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic        win_id;

  // On a tie the requester not served last wins; otherwise the lone requester wins.
  assign win_id = (req_valid == 2'b11) ? ~last_id_q : req_valid[1];

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    err_d       = err_q;
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    mul_din_rdy = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          req_ready = win_id ? 2'b10 : 2'b01;
          op_a_d    = win_id ? req_a[63:32] : req_a[31:0];
          op_b_d    = win_id ? req_b[63:32] : req_b[31:0];
          gnt_id_d  = win_id;
          cnt_d     = 8'd0;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        mul_din_rdy = 1'b1;
        state_d     = WAIT_RES;
      end
      WAIT_RES: begin
        // The multiplier drops dout_rdy on the issue edge, so a high level here is fresh.
        if (mul_dout_rdy) begin
          res_d   = mul_dout;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = QNAN;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RESP: begin
        rsp_valid = gnt_id_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_id_q]) begin
          last_id_d = gnt_id_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      op_a_q    <= '0;
      op_b_q    <= '0;
      gnt_id_q  <= 1'b0;
      last_id_q <= 1'b1;
      cnt_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      gnt_id_q  <= gnt_id_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      err_q     <= err_d;
    end
  end

  assign rsp_data = res_q;
  assign rsp_err  = err_q & (state_q == RESP);
  assign busy     = (state_q != IDLE);
  assign mul_din1 = op_a_q;
  assign mul_din2 = op_b_q;

endmodule

// File: tb/tb_vmul_arb.sv
// Self-checking bench for vmul_arb: directed table, corner-case sequences and random traffic
// against a round-robin reference model, with a stand-in multiplier of variable latency.
module tb_vmul_arb;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [63:0] req_a, req_b;
  logic [1:0]  req_ready, rsp_valid, rsp_ready;
  logic [31:0] rsp_data, mul_din1, mul_din2, mul_dout;
  logic        rsp_err, busy, mul_din_rdy, mul_dout_rdy;

  int n_checks = 0;
  int n_fail   = 0;

  vmul_arb #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy),
    .mul_din1(mul_din1), .mul_din2(mul_din2), .mul_din_rdy(mul_din_rdy),
    .mul_dout(mul_dout), .mul_dout_rdy(mul_dout_rdy)
  );

  always #5 clk = ~clk;

  // Stand-in multiplier: special operands take 3 cycles, others lat_cfg cycles; stall freezes it.
  logic        m_rdy, m_busy, stall;
  logic [31:0] m_res;
  int          m_rem;
  int          lat_cfg;

  function automatic logic is_special(input logic [31:0] x);
    return (x[30:23] == 8'hFF) || (x[30:23] == 8'h00);
  endfunction

  function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (a == 32'h3F80_0000 && b == 32'h3F80_0000) return 32'h3F80_0000;
    if (is_special(a) || is_special(b)) return 32'hFFFF_FFFF;
    return {a[31] ^ b[31], a[30:0] ^ {b[29:0], b[30]}};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rdy  <= 1'b0;
      m_busy <= 1'b0;
      m_rem  <= 0;
      m_res  <= '0;
    end else if (mul_din_rdy) begin
      m_rdy  <= 1'b0;
      m_busy <= 1'b1;
      m_res  <= mul_fn(mul_din1, mul_din2);
      m_rem  <= ((is_special(mul_din1) || is_special(mul_din2)) ? 3 : lat_cfg) - 2;
    end else if (m_busy && !stall) begin
      if (m_rem == 0) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
      end else begin
        m_rem <= m_rem - 1;
      end
    end
  end

  assign mul_dout     = m_res;
  assign mul_dout_rdy = m_rdy;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transaction; entered and left just after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input logic [1:0] vld, input logic [63:0] a,
                        input logic [63:0] b, input logic [1:0] exp_gnt,
                        input logic [31:0] exp_data, input logic exp_err, input bit hold,
                        input bit tie, input int rsp_delay, output int rsp_cyc);
    int          waits;
    int          k;
    logic [31:0] aw, bw;
    rsp_cyc   = -1;
    req_a     = a;
    req_b     = b;
    req_valid = vld;
    rsp_ready = tie ? 2'b11 : 2'b00;
    waits     = 0;
    @(negedge clk);
    while ((req_ready & req_valid) == 2'b00 && waits < 300) begin
      waits++;
      @(negedge clk);
    end
    check({tag, "/accept_now"}, waits, 0);
    if (waits >= 300) begin
      req_valid = 2'b00;
      return;
    end
    check({tag, "/gnt"}, req_ready, exp_gnt);
    check({tag, "/idle_outs"}, {busy, rsp_valid, mul_din_rdy}, '0);
    aw = exp_gnt[1] ? a[63:32] : a[31:0];
    bw = exp_gnt[1] ? b[63:32] : b[31:0];

    @(posedge clk); #1;
    if (!hold) req_valid = vld & ~exp_gnt;
    @(negedge clk);
    check({tag, "/issue"}, {mul_din_rdy, mul_din1, mul_din2}, {1'b1, aw, bw});
    check({tag, "/issue_busy"}, {busy, req_ready}, {1'b1, 2'b00});

    k = -1;
    for (int c = 2; c <= TO + 10; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (rsp_valid != 2'b00) begin
        rsp_cyc = c;
        break;
      end
      check({tag, "/wait_quiet"}, {mul_din_rdy, req_ready, busy}, {1'b0, 2'b00, 1'b1});
      if (k < 0 && mul_dout_rdy) k = c;
    end
    check({tag, "/lat"}, rsp_cyc, (k >= 0) ? k + 1 : TO + 2);
    if (rsp_cyc < 0) begin
      req_valid = 2'b00;
      return;
    end
    check({tag, "/rsp"}, {rsp_valid, rsp_data, rsp_err}, {exp_gnt, exp_data, exp_err});

    if (!tie) begin
      for (int d = 0; d < rsp_delay; d++) begin
        @(posedge clk); #1;
        rsp_ready = ~exp_gnt;
        @(negedge clk);
        check({tag, "/hold"}, {rsp_valid, rsp_data, rsp_err, req_ready},
              {exp_gnt, exp_data, exp_err, 2'b00});
      end
      @(posedge clk); #1;
      rsp_ready = exp_gnt;
    end
    @(posedge clk); #1;
    if (!tie) rsp_ready = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [63:0] a;
    logic [63:0] b;
    logic [1:0]  gnt;
    logic [31:0] data;
    int          lat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL global_watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rc;
    int          w;
    int          model_last;
    logic [1:0]  v, g;
    logic [63:0] ra, rb;

    vecs[0] = '{2'b01, {32'h0, 32'h4000_0000}, {32'h0, 32'h4040_0000}, 2'b01, 32'h40C0_0000, 0};
    vecs[1] = '{2'b10, {32'h7F80_0000, 32'h0}, {32'h0, 32'h0}, 2'b10, 32'hFFFF_FFFF, 5};
    vecs[2] = '{2'b11, {32'h4000_0000, 32'h3F80_0000}, {32'h4040_0000, 32'h3F80_0000},
                2'b01, 32'h3F80_0000, 0};
    vecs[3] = '{2'b11, {32'h4000_0000, 32'h3F80_0000}, {32'h4040_0000, 32'h3F80_0000},
                2'b10, 32'h40C0_0000, 0};
    vecs[4] = '{2'b10, {32'h7F80_0000, 32'h1234_5678}, {32'h0, 32'h4000_0000},
                2'b10, 32'hFFFF_FFFF, 5};
    vecs[5] = '{2'b11, {32'h3F80_0000, 32'h0}, {32'h3F80_0000, 32'h3F80_0000},
                2'b01, 32'hFFFF_FFFF, 5};
    vecs[6] = '{2'b10, {32'h3F80_0000, 32'h0}, {32'h3F80_0000, 32'h0},
                2'b10, 32'h3F80_0000, 0};

    rst       = 1'b0;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 2'b00;
    stall     = 1'b0;
    lat_cfg   = 5;

    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {req_ready, rsp_valid, rsp_data, rsp_err, busy, mul_din1, mul_din2,
                         mul_din_rdy}, '0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("post_reset_idle", {req_ready, rsp_valid, busy, mul_din_rdy}, '0);
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].vld, vecs[i].a, vecs[i].b, vecs[i].gnt,
             vecs[i].data, 1'b0, 1'b0, 1'b0, i % 3, rc);
      if (vecs[i].lat != 0) check($sformatf("vec%0d/special_lat", i), rc, vecs[i].lat);
    end

    // Backpressure: requester 1 waits behind a 20-cycle stalled response to requester 0
    run_op("bp", 2'b11, {32'h3F80_0000, 32'h4000_0000}, {32'h3F80_0000, 32'h4040_0000},
           2'b01, 32'h40C0_0000, 1'b0, 1'b0, 1'b0, 20, rc);
    run_op("bp_next", 2'b10, {32'h3F80_0000, 32'h0}, {32'h3F80_0000, 32'h0},
           2'b10, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, 0, rc);

    // Timeout
    stall = 1'b1;
    run_op("timeout", 2'b01, {32'h0, 32'h4000_0000}, {32'h0, 32'h4040_0000},
           2'b01, 32'h7FC0_0000, 1'b1, 1'b0, 1'b0, 2, rc);
    check("timeout/cycle", rc, 66);
    stall = 1'b0;

    // Reset during WAIT_RES
    stall     = 1'b1;
    req_a     = {32'h0, 32'h4000_0000};
    req_b     = {32'h0, 32'h4040_0000};
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid/pre", {busy, mul_din1}, {1'b1, 32'h4000_0000});
    rst = 1'b0;
    #1;
    check("rst_mid/outs", {req_ready, rsp_valid, rsp_data, rsp_err, mul_din1, mul_din2,
                           mul_din_rdy}, '0);
    check("rst_mid/busy", busy, 1'b0);
    @(posedge clk); #1;
    stall = 1'b0;
    rst   = 1'b1;

    // Contention straight after reset: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      run_op($sformatf("cont%0d", i), 2'b11, {32'h3F80_0000, 32'h3F80_0000},
             {32'h3F80_0000, 32'h3F80_0000}, (i % 2 == 0) ? 2'b01 : 2'b10,
             32'h3F80_0000, 1'b0, 1'b1, 1'b1, 0, rc);
    end
    req_valid  = 2'b00;
    rsp_ready  = 2'b00;
    model_last = 1;

    // Random traffic against the round-robin model
    for (int i = 0; i < 40; i++) begin
      v  = 2'($urandom_range(1, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 4) == 0) ra[30:23] = 8'hFF;
      if ($urandom_range(0, 4) == 0) rb[62:55] = 8'h00;
      lat_cfg = $urandom_range(2, 9);
      w = (v == 2'b11) ? 1 - model_last : ((v == 2'b10) ? 1 : 0);
      g = (w == 1) ? 2'b10 : 2'b01;
      run_op($sformatf("rand%0d", i), v, ra, rb, g,
             mul_fn((w == 1) ? ra[63:32] : ra[31:0], (w == 1) ? rb[63:32] : rb[31:0]),
             1'b0, 1'b0, 1'b0, $urandom_range(0, 4), rc);
      model_last = w;
    end

    @(negedge clk);
    check("final_idle", {busy, rsp_valid, req_ready}, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
